// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester hold-limited arbiter.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/prio_pick_4.sv
// Fixed-priority pick: highest set bit of vec wins, reported as one-hot and binary index.
module prio_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |vec;
    // Ascending scan so the highest set bit is the last one written.
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter_hold_4.sv
// Four-way fixed-priority arbiter with a bounded grant hold and one-shot mask of the expired owner.
module arbiter_hold_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             expired
);

  arb_state_t        r_state, w_state_next;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_next;
  logic              r_busy, w_busy_next;
  logic              r_expired, w_expired_next;
  logic [N_REQ-1:0]  r_mask, w_mask_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;

  logic [N_REQ-1:0]  w_eligible;
  logic [N_REQ-1:0]  w_pick_vec;
  logic [N_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_owner_req;
  logic              w_hold_full;

  // The mask only steers choice among several requesters; a lone masked requester still wins.
  assign w_eligible  = req & ~r_mask;
  assign w_pick_vec  = (|w_eligible) ? w_eligible : req;
  assign w_owner_req = |(req & r_gnt);
  assign w_hold_full = (r_hold_cnt == HOLD_W'(MAX_HOLD));

  prio_pick_4 u_pick (
    .vec    (w_pick_vec),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_gnt_idx_next  = r_gnt_idx;
    w_busy_next     = r_busy;
    w_expired_next  = 1'b0;
    w_mask_next     = r_mask;
    w_hold_cnt_next = r_hold_cnt;

    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_next    = GRANT;
          w_gnt_next      = w_pick_onehot;
          w_gnt_idx_next  = w_pick_idx;
          w_busy_next     = 1'b1;
          w_mask_next     = '0;
          w_hold_cnt_next = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!w_owner_req || w_hold_full) begin
          // A voluntary drop wins over expiry, so the mask is only set on a forced release.
          w_state_next    = IDLE;
          w_gnt_next      = '0;
          w_gnt_idx_next  = '0;
          w_busy_next     = 1'b0;
          w_hold_cnt_next = '0;
          w_mask_next     = w_owner_req ? r_gnt : '0;
          w_expired_next  = w_owner_req;
        end else begin
          w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_busy     <= 1'b0;
      r_expired  <= 1'b0;
      r_mask     <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_gnt_idx  <= w_gnt_idx_next;
      r_busy     <= w_busy_next;
      r_expired  <= w_expired_next;
      r_mask     <= w_mask_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

// File: doc/arbiter_hold_4.md
ARBITER_HOLD_4 -- requirements
Module: arbiter_hold_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive cycles one grant is held (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req  input  4  SHALL carry level requests; bit 3 has the highest priority, bit 0 the lowest.
REQ-005 gnt  output  4  SHALL be a registered grant, one-hot or all-zero.
REQ-006 gnt_idx  output  2  SHALL be the binary index of the set gnt bit, and 0 when gnt is zero.
REQ-007 busy  output  1  SHALL be 1 exactly when gnt is nonzero.
REQ-008 expired  output  1  SHALL be a one-cycle pulse marking a forced release.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-010 In IDLE with eligible = req & ~mask nonzero, the next state SHALL be GRANT, with gnt set to the highest set bit of eligible.
REQ-011 In IDLE with eligible zero and req nonzero, the block SHALL grant the highest set bit of req; the mask SHALL NOT starve a lone requester.
REQ-012 In IDLE with req zero, the block SHALL remain in IDLE.
REQ-013 Grant latency SHALL be exactly 1 cycle: a req sampled in IDLE at edge N SHALL produce gnt valid after edge N.
REQ-014 hold_cnt (8-bit) SHALL be 1 in the first GRANT cycle and increment each further GRANT cycle.
REQ-015 In GRANT, if req[owner]=0, the next state SHALL be IDLE, with gnt=0 and mask cleared.
REQ-016 In GRANT, if req[owner]=1 and hold_cnt=MAX_HOLD, the next state SHALL be IDLE, gnt=0, mask set to the owner bit, and expired=1 for that single IDLE cycle.
REQ-017 In GRANT, if req[owner]=1 and hold_cnt<MAX_HOLD, gnt SHALL hold unchanged; other requests SHALL be ignored (no preemption).
REQ-018 If req[owner] drops in the cycle hold_cnt=MAX_HOLD, the release SHALL be treated as normal: expired=0 and mask cleared.
REQ-019 At least one all-zero gnt cycle SHALL separate any two grants, including a re-grant to the same requester.
REQ-020 The mask SHALL be cleared when any grant is issued.
REQ-021 gnt_idx and busy SHALL be registered alongside gnt, with no combinational path from req.

Reset
REQ-022 While reset=1 at a clock edge, the following SHALL hold next cycle: state=IDLE, gnt=0, gnt_idx=0, busy=0, expired=0, mask=0, hold_cnt=0.
REQ-023 A reset asserted during GRANT SHALL abort the grant with no expired pulse.
REQ-024 The first grant SHALL be possible on the first edge after reset deasserts.

Structure
REQ-025 Package arb_pkg SHALL hold the state enum (IDLE, GRANT), the constant N_REQ=4 and the hold-counter width.
REQ-026 The combinational highest-bit pick and index encode SHALL live in one sub-module, prio_pick_4 (in: vec[3:0]; out: onehot[3:0], idx[1:0], any).

Verification (MAX_HOLD=4)
REQ-027 req=0110 from IDLE -> next cycle gnt=0100, gnt_idx=2, busy=1.
REQ-028 Owner 0100 drops req while req=0010 -> gnt=0000 for 1 cycle, then gnt=0010, gnt_idx=1.
REQ-029 req=1001 held constant -> gnt=1000 for 4 cycles; expired=1 with gnt=0000; then gnt=0001; after 4 more cycles gnt=0000, then gnt=1000.
REQ-030 req=1000 alone held -> gnt=1000 for 4 cycles, 1 idle cycle with expired=1, then gnt=1000 again.
REQ-031 req[owner] drops exactly at hold_cnt=4 -> gnt=0000 and expired=0 next cycle.
REQ-032 reset pulsed at hold_cnt=2 -> next cycle all outputs 0, no expired pulse; req=0100 afterwards -> gnt=0100 one cycle after reset deasserts.
